// File: rtl/serial_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_pkg
// Description : Shared definitions for the serial transmitter and receiver:
//               receiver state encoding, default bit period, byte width and
//               a 2-of-3 majority helper.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_pkg;

    localparam int BYTE_W               = 8;
    localparam int DEFAULT_CLKS_PER_BIT = 104;   // 12 MHz / 115200

    localparam int STATE_W = 3;
    localparam logic [STATE_W-1:0] IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] START     = 3'd1;
    localparam logic [STATE_W-1:0] DATA      = 3'd2;
    localparam logic [STATE_W-1:0] STOP      = 3'd3;
    localparam logic [STATE_W-1:0] WAIT_IDLE = 3'd4;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_rx_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_rx_if
// Description : Receive-side bundle of the UART receiver.
//               rx        - serial line (idles high)
//               rbyte     - last correctly framed byte
//               rbyte_rdy - one-cycle strobe, rbyte is new
//               frame_err - one-cycle strobe, stop bit sampled low
//               busy      - receiver not idle
//               slave  : the receiver (consumes rx, produces the rest)
//               master : the line driver / byte consumer
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_rx_if;
    import serial_pkg::*;

    logic              rx;
    logic [BYTE_W-1:0] rbyte;
    logic              rbyte_rdy;
    logic              frame_err;
    logic              busy;

    modport slave  (input rx, output rbyte, output rbyte_rdy, output frame_err, output busy);
    modport master (output rx, input rbyte, input rbyte_rdy, input frame_err, input busy);

endinterface
`default_nettype wire

// File: rtl/serial_rx_sync.sv
`default_nettype none
// ============================================================================
// Module      : rx_sync
// Description : Two-flop synchronizer for the asynchronous rx line. With
//               SERIAL_RX_MAJORITY_EN defined it also keeps a 3-tap history
//               of the synchronized line and outputs a 2-of-3 vote.
// Ports       : clk12   in  - system clock
//               rst_n   in  - synchronous reset, active-low
//               rx      in  - raw serial line
//               rx_s    out - synchronized line (2 cycles behind rx)
//               rx_vote out - value the receiver samples at a bit point
// Macro       : SERIAL_RX_MAJORITY_EN
// Revision    : 1.0 - initial release
// ============================================================================
module rx_sync
    import serial_pkg::*;
(
    input  wire logic clk12,
    input  wire logic rst_n,
    input  wire logic rx,
    output logic      rx_s,
    output logic      rx_vote
);

    logic r_sync1;
    logic r_sync2;

    // Reset to the idle level so no false start is seen out of reset.
    always_ff @(posedge clk12) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
        end
    end

    assign rx_s = r_sync2;

`ifdef SERIAL_RX_MAJORITY_EN
    logic r_tap1;
    logic r_tap2;

    always_ff @(posedge clk12) begin
        if (!rst_n) begin
            r_tap1 <= 1'b1;
            r_tap2 <= 1'b1;
        end else begin
            r_tap1 <= r_sync2;
            r_tap2 <= r_tap1;
        end
    end

    // When the FSM decides at target+1, the taps hold target and target-1.
    assign rx_vote = majority3(r_sync2, r_tap1, r_tap2);
`else
    assign rx_vote = r_sync2;
`endif

endmodule
`default_nettype wire

// File: rtl/serial_rx.sv
`default_nettype none
// ============================================================================
// Module      : serial_rx
// Description : UART receiver, 8N1, LSB first. Detects the start edge,
//               confirms it at mid-start, samples each data bit and the stop
//               bit at mid-bit, strobes good bytes and flags framing errors.
// Ports       : clk12  in  - system clock (rising edge)
//               rst_n  in  - synchronous reset, active-low
//               bus    slave modport of serial_rx_if
//                      (rx in; rbyte, rbyte_rdy, frame_err, busy out)
// Parameters  : CLKS_PER_BIT - clk12 cycles per bit, >= 8
//               CNT_W        - bit counter width, 2**CNT_W > CLKS_PER_BIT
// Macro       : SERIAL_RX_MAJORITY_EN - 2-of-3 vote around each sample point,
//               decisions move one cycle later.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_rx
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int CNT_W        = 16
) (
    input  wire logic   clk12,
    input  wire logic   rst_n,
    serial_rx_if.slave  bus
);

`ifdef SERIAL_RX_MAJORITY_EN
    localparam int c_maj = 1;
`else
    localparam int c_maj = 0;
`endif

    // Only the start check shifts by one cycle; data and stop decisions are
    // spaced a full bit period after it, so they inherit the same shift.
    localparam logic [CNT_W-1:0] c_start_cmp = CNT_W'(CLKS_PER_BIT / 2 - 1 + c_maj);
    localparam logic [CNT_W-1:0] c_bit_last  = CNT_W'(CLKS_PER_BIT - 1);

    logic w_rx_s;
    logic w_rx_vote;

    logic [STATE_W-1:0] r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_idx;
    logic [BYTE_W-1:0]  r_shift;
    logic [BYTE_W-1:0]  r_rbyte;
    logic               r_rdy;
    logic               r_ferr;
    logic               r_busy;
    // Out of reset the synchronizer holds its forced-high values for two
    // cycles; r_settle waits those out so that r_armed is only set by a high
    // level really seen on the line. This keeps the tail of a frame
    // interrupted by reset from being taken as a new start bit.
    logic [1:0]         r_settle;
    logic               r_armed;

    rx_sync u_rx_sync (
        .clk12   (clk12),
        .rst_n   (rst_n),
        .rx      (bus.rx),
        .rx_s    (w_rx_s),
        .rx_vote (w_rx_vote)
    );

    always_ff @(posedge clk12) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_idx    <= 3'd0;
            r_shift  <= '0;
            r_rbyte  <= '0;
            r_rdy    <= 1'b0;
            r_ferr   <= 1'b0;
            r_busy   <= 1'b0;
            r_settle <= 2'd0;
            r_armed  <= 1'b0;
        end else begin
            r_rdy  <= 1'b0;
            r_ferr <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (r_settle != 2'd2) begin
                        r_settle <= r_settle + 2'd1;
                    end else if (w_rx_s) begin
                        r_armed <= 1'b1;
                    end else if (r_armed) begin
                        r_state <= START;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                    end
                end

                START: begin
                    if (r_cnt == c_start_cmp) begin
                        r_cnt <= '0;
                        if (!w_rx_vote) begin
                            r_state <= DATA;
                            r_idx   <= 3'd0;
                        end else begin
                            r_state <= IDLE;   // glitch, not a start bit
                            r_busy  <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx_vote, r_shift[BYTE_W-1:1]};
                        r_idx   <= r_idx + 3'd1;
                        if (r_idx == 3'd7) begin
                            r_state <= STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                STOP: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt <= '0;
                        if (w_rx_vote) begin
                            // Leave at mid-stop: half a bit of slack for a
                            // back-to-back start edge.
                            r_rbyte <= r_shift;
                            r_rdy   <= 1'b1;
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_ferr  <= 1'b1;
                            r_state <= WAIT_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                WAIT_IDLE: begin
                    // A break holds the line low; no bytes until it recovers.
                    if (w_rx_s) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                end

                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rbyte     = r_rbyte;
    assign bus.rbyte_rdy = r_rdy;
    assign bus.frame_err = r_ferr;
    assign bus.busy      = r_busy;

endmodule
`default_nettype wire

// File: doc/serial_rx.md
Name: serial_rx

Overview:
- UART receiver, 8N1, LSB first. It is the receive-side counterpart of the existing `serial` transmitter.
- Recovers bytes from the board SERIAL_RX pin, clocked from the PLL-derived clk12 domain.
- Delivers each byte with a one-cycle ready strobe, for the display path and for the LFSR loopback check at top level.
- Oversamples with a per-bit clock counter and samples at mid-bit; flags framing errors.

Parameters:
- CLKS_PER_BIT, 104, clk12 cycles per bit (12 MHz / 115200). Minimum legal value 8.
- CNT_W, 16, width of the bit-period counter. Must satisfy 2^CNT_W > CLKS_PER_BIT.

Ports:
- clk12  input  1  single system clock; all logic on its rising edge.
- rst_n  input  1  synchronous reset, active-low.
- rx  input  1  asynchronous serial line; idles high.
- rbyte  output  8  last correctly framed byte; held until the next good byte.
- rbyte_rdy  output  1  one-cycle pulse; rbyte is valid and new.
- frame_err  output  1  one-cycle pulse; stop bit sampled low.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst_n=0 at a clock edge) sets: state=IDLE, counter=0, bit index=0, shift register=0, rbyte=8'h00, rbyte_rdy=0, frame_err=0, busy=0, synchronizer flops=1.
- Reset mid-frame abandons the frame with no strobe. The next start bit is accepted only after rx_s has been seen high in IDLE.
- rx passes through a 2-FF synchronizer to give rx_s. All decisions use rx_s, which lags rx by 2 cycles.
- States are IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE:
  - rx_s==0 → go to START with counter=0.
  - Otherwise stay.
- START:
  - Counter increments each cycle.
  - At counter==CLKS_PER_BIT/2-1 (integer division), sample rx_s.
  - Sample 0 → go to DATA with counter=0, bit index=0.
  - Sample 1 → false start (glitch); go back to IDLE with no strobe.
- DATA:
  - At counter==CLKS_PER_BIT-1, sample rx_s into shift[7] and shift the register right, so the result is LSB first.
  - Reset the counter and increment the bit index.
  - After the sample at bit index 7 → go to STOP with counter=0.
- STOP:
  - At counter==CLKS_PER_BIT-1, sample rx_s.
  - Sample 1 → rbyte<=shift and rbyte_rdy=1 for exactly the next cycle; go to IDLE.
  - IDLE is entered at mid-stop, giving half a bit of slack for a back-to-back start bit.
  - Sample 0 → frame_err=1 for one cycle; rbyte is unchanged; go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s==1, then go to IDLE. A break condition therefore never yields bytes.
- rbyte_rdy and frame_err are never high in the same cycle.
- Latency: rbyte_rdy rises 1 cycle after the mid-stop sample, which is ≈9.5 bit times plus 3 cycles after the rx start edge.
- Counters use CNT_W-bit unsigned arithmetic. The compare-and-clear prevents wrap; the bit index is 3 bits.
- Tolerance: correct reception with total baud mismatch up to ±4%.

Optional Feature:
- Macro: SERIAL_RX_MAJORITY_EN.
- Defined:
  - Each sample point (start check, data bits, stop) uses a 2-of-3 majority of rx_s taken at counter values target-1, target and target+1.
  - The state advance moves to target+1, so latency grows by 1 cycle.
  - A single-cycle glitch at the sample point is rejected.
- Undefined: single sample at the target counter value, exactly as described under Behaviour.

Decomposition:
- Package serial_pkg holds:
  - the state encoding localparams (IDLE=0, START=1, DATA=2, STOP=3, WAIT_IDLE=4);
  - DEFAULT_CLKS_PER_BIT=104;
  - BYTE_W=8.
- The `serial` transmitter shares serial_pkg.
- One sub-module: rx_sync.
  - Contains the 2-FF synchronizer and, under SERIAL_RX_MAJORITY_EN, the 3-tap sample history with the majority vote.
  - Outputs rx_s and rx_vote.
- The FSM, counters and datapath stay in serial_rx.

Test Plan (CLKS_PER_BIT=16 unless noted):
- Idle line, then frame 0xA5 → one rbyte_rdy pulse with rbyte=8'hA5; busy high for ≈152 cycles; frame_err stays 0.
- rx low for 4 cycles in IDLE, then high → busy pulses, returns to IDLE, no rbyte_rdy, no frame_err.
- Frame 0x3C with the stop bit driven 0 and the line held low 40 cycles → one frame_err pulse; rbyte keeps the prior 8'hA5; no further strobe until the line returns high.
- Back-to-back 0x00, 0xFF, 0x55 with zero idle gap, TX period 16.6 cycles/bit (+4%) → three strobes with the correct bytes in order.
- rst_n=0 for 1 cycle during data bit 3 of 0x81, then a clean frame 0x7E → no strobe for the aborted frame; rbyte=8'h00, then 8'h7E.
- Loopback: LFSR plus `serial` TX driving serial_rx at CLKS_PER_BIT=104 for 256 bytes → every rbyte equals the transmitted byte; zero frame_err. With SERIAL_RX_MAJORITY_EN, a 1-cycle inverted glitch injected at every mid-bit → same result.
